// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared RV32I ALU encodings (funct3 / funct7[5]) and the status
//            flag bundle carried alongside every ALU result.
// Config   : flag bundle is only used when ALU_FLAGS_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // funct3 operation select, RV32I OP encoding
  localparam logic [2:0] ALU_F3_ADD  = 3'd0;  // ADD / SUB
  localparam logic [2:0] ALU_F3_SLL  = 3'd1;
  localparam logic [2:0] ALU_F3_SLT  = 3'd2;
  localparam logic [2:0] ALU_F3_SLTU = 3'd3;
  localparam logic [2:0] ALU_F3_XOR  = 3'd4;
  localparam logic [2:0] ALU_F3_SRL  = 3'd5;  // SRL / SRA
  localparam logic [2:0] ALU_F3_OR   = 3'd6;
  localparam logic [2:0] ALU_F3_AND  = 3'd7;

  // funct7[5]: selects the alternate form (SUB, SRA) of ADD and SRL
  localparam logic ALU_F7_BASE = 1'b0;
  localparam logic ALU_F7_ALT  = 1'b1;

  // Status flags that travel with a result through the pipe
  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
  } alu_result_t;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_core
// Purpose  : Purely combinational RV32I register-register ALU: op decode and
//            compute, plus zero/carry/overflow status.
// Config   : ALU_FLAGS_EN adds the flags output
// Revision : 1.0 - initial release
// ============================================================================
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] result
`ifdef ALU_FLAGS_EN
  ,
  output alu_result_t     flags
`endif
);

  localparam int SHW = $clog2(XLEN);

  logic            w_sub;
  logic [XLEN-1:0] w_b;
  logic [XLEN:0]   w_sum;
  logic [SHW-1:0]  w_shamt;
  logic            w_slt;
  logic            w_sltu;

  // SUB reuses the adder as rs1 + ~rs2 + 1 so carry-out is the no-borrow bit
  assign w_sub   = (funct3 == ALU_F3_ADD) && (funct7_5 == ALU_F7_ALT);
  assign w_b     = w_sub ? ~rs2 : rs2;
  assign w_sum   = {1'b0, rs1} + {1'b0, w_b} + {{XLEN{1'b0}}, w_sub};
  assign w_shamt = rs2[SHW-1:0];
  assign w_slt   = $signed(rs1) < $signed(rs2);
  assign w_sltu  = rs1 < rs2;

  // Result multiplexer on funct3
  always_comb begin
    result = '0;
    case (funct3)
      ALU_F3_ADD:  result = w_sum[XLEN-1:0];
      ALU_F3_SLL:  result = rs1 << w_shamt;
      ALU_F3_SLT:  result = {{(XLEN-1){1'b0}}, w_slt};
      ALU_F3_SLTU: result = {{(XLEN-1){1'b0}}, w_sltu};
      ALU_F3_XOR:  result = rs1 ^ rs2;
      ALU_F3_SRL:  result = (funct7_5 == ALU_F7_ALT) ? $unsigned($signed(rs1) >>> w_shamt)
                                                      : (rs1 >> w_shamt);
      ALU_F3_OR:   result = rs1 | rs2;
      ALU_F3_AND:  result = rs1 & rs2;
      default:     result = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  // Carry/overflow only meaningful for ADD/SUB; zero covers every op
  always_comb begin
    flags          = '0;
    flags.zero     = (result == '0);
    if (funct3 == ALU_F3_ADD) begin
      flags.carry    = w_sum[XLEN];
      flags.overflow = (rs1[XLEN-1] == w_b[XLEN-1]) && (w_sum[XLEN-1] != rs1[XLEN-1]);
    end
  end
`else
  logic w_unused_carry;
  assign w_unused_carry = w_sum[XLEN];
`endif

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Purpose  : STAGES-deep pipelined RV32I ALU with valid/ready on both sides
//            and a global enable that freezes the whole pipe.
// Config   : ALU_FLAGS_EN adds registered flag_zero/carry/overflow outputs
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic [XLEN-1:0] register_data_1,
  input  logic [XLEN-1:0] register_data_2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] register_data_out
`ifdef ALU_FLAGS_EN
  ,
  output logic            flag_zero,
  output logic            flag_carry,
  output logic            flag_overflow
`endif
);

  logic [XLEN-1:0] w_result;
  logic            w_advance;
  logic            r_valid [STAGES];
  logic [XLEN-1:0] r_data  [STAGES];
`ifdef ALU_FLAGS_EN
  alu_result_t     w_flags;
  alu_result_t     r_flags [STAGES];
`endif

  alu_core #(
    .XLEN (XLEN)
  ) u_core (
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .rs1      (register_data_1),
    .rs2      (register_data_2),
    .result   (w_result)
`ifdef ALU_FLAGS_EN
    ,
    .flags    (w_flags)
`endif
  );

  // Whole pipe moves as one; bubbles are not collapsed under a stalled output
  assign w_advance = enable && !reset && (!r_valid[STAGES-1] || out_ready);
  assign in_ready  = w_advance;

  // Stage registers: clear on reset, shift on advance, otherwise hold
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        r_valid[i] <= 1'b0;
        r_data[i]  <= '0;
`ifdef ALU_FLAGS_EN
        r_flags[i] <= '0;
`endif
      end
    end else if (w_advance) begin
      r_valid[0] <= in_valid;
      r_data[0]  <= w_result;
`ifdef ALU_FLAGS_EN
      r_flags[0] <= w_flags;
`endif
      for (int i = 1; i < STAGES; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
`ifdef ALU_FLAGS_EN
        r_flags[i] <= r_flags[i-1];
`endif
      end
    end
  end

  assign out_valid         = r_valid[STAGES-1];
  assign register_data_out = r_data[STAGES-1];
`ifdef ALU_FLAGS_EN
  assign flag_zero         = r_flags[STAGES-1].zero;
  assign flag_carry        = r_flags[STAGES-1].carry;
  assign flag_overflow     = r_flags[STAGES-1].overflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Purpose  : Self-checking bench for alu_pipe (XLEN=32, STAGES=2) against a
//            behavioural reference model and an in-order scoreboard.
// Config   : flag outputs are compared when ALU_FLAGS_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

  localparam int XLEN   = 32;
  localparam int STAGES = 2;

  logic        clk = 1'b0;
  logic        reset, enable, in_valid, in_ready, funct7_5;
  logic [2:0]  funct3;
  logic [31:0] register_data_1, register_data_2, register_data_out;
  logic        out_valid, out_ready;
  logic [2:0]  obs_flg;

  always #5 clk = ~clk;

  alu_pipe #(
    .XLEN   (XLEN),
    .STAGES (STAGES)
  ) dut (
    .clock             (clk),
    .reset             (reset),
    .enable            (enable),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .funct3            (funct3),
    .funct7_5          (funct7_5),
    .register_data_1   (register_data_1),
    .register_data_2   (register_data_2),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .register_data_out (register_data_out)
`ifdef ALU_FLAGS_EN
    ,
    .flag_zero         (obs_flg[2]),
    .flag_carry        (obs_flg[1]),
    .flag_overflow     (obs_flg[0])
`endif
  );
`ifndef ALU_FLAGS_EN
  assign obs_flg = 3'b000;
`endif

  typedef struct {
    logic [31:0] data;
    logic [2:0]  flg;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          n_timeouts = 0;
  int          seen_timeouts = 0;
  logic [31:0] cur_d = '0;
  logic [2:0]  cur_f = '0;
  bit          lat_mode = 1'b0;
  bit          prev_hold = 1'b0;
  bit          prev_reset = 1'b0;
  logic [31:0] prev_data = '0;
  logic [2:0]  prev_flg = '0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference ALU written from the instruction definitions
  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic f7,
                                          input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (f3)
      3'd0: return f7 ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        if (f7 && a[31]) return ~((~a) >> sh);
        return a >> sh;
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Reference flags {zero, carry, overflow}
  function automatic logic [2:0] ref_flags(input logic [2:0] f3, input logic f7,
                                           input logic [31:0] a, input logic [31:0] b);
    longint s;
    logic   z, c, o;
    z = (ref_alu(f3, f7, a, b) == 32'd0);
    c = 1'b0;
    o = 1'b0;
    if (f3 == 3'd0) begin
      if (f7) begin
        c = (a >= b);
        s = longint'(int'(a)) - longint'(int'(b));
      end else begin
        c = ((longint'(a) + longint'(b)) > 64'sd4294967295);
        s = longint'(int'(a)) + longint'(int'(b));
      end
      o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
    return {z, c, o};
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard / protocol monitor, sampled midway between rising edges
  always @(negedge clk) begin
    cyc++;
    check_value("in_ready", 64'(in_ready), 64'(enable && !reset && (!out_valid || out_ready)));
    if (prev_reset) begin
      check_value("reset_valid", 64'(out_valid), 64'd0);
      check_value("reset_data", 64'(register_data_out), 64'd0);
    end
    if (prev_hold) begin
      check_value("hold_valid", 64'(out_valid), 64'd1);
      check_value("hold_data", 64'(register_data_out), 64'(prev_data));
`ifdef ALU_FLAGS_EN
      check_value("hold_flags", 64'(obs_flg), 64'(prev_flg));
`endif
    end
    if (reset) begin
      q.delete();
    end else begin
      if (out_valid && out_ready && enable) begin
        if (q.size() == 0) begin
          check_value("spurious_result", 64'(register_data_out), 64'hDEAD_0000_0000_0000);
        end else begin
          e = q.pop_front();
          check_value("result", 64'(register_data_out), 64'(e.data));
`ifdef ALU_FLAGS_EN
          check_value("flags", 64'(obs_flg), 64'(e.flg));
`endif
          if (e.lat) check_value("latency", 64'(cyc - e.cyc), 64'(STAGES));
        end
      end
      if (in_valid && in_ready) q.push_back('{cur_d, cur_f, cyc, lat_mode});
    end
    if (n_timeouts != seen_timeouts) begin
      check_value("timeout", 64'(n_timeouts), 64'(seen_timeouts));
      seen_timeouts = n_timeouts;
    end
    prev_reset = reset;
    prev_hold  = out_valid && !(out_ready && enable) && !reset;
    prev_data  = register_data_out;
    prev_flg   = obs_flg;
  end

  task automatic drive(input logic [2:0] f3, input logic f7, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_d, input logic [2:0] exp_f);
    funct3 = f3; funct7_5 = f7; register_data_1 = a; register_data_2 = b;
    cur_d = exp_d; cur_f = exp_f; in_valid = 1'b1;
  endtask

  // Present one op and wait (bounded) until it is accepted
  task automatic send(input logic [2:0] f3, input logic f7, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_d, input logic [2:0] exp_f);
    int t;
    drive(f3, f7, a, b, exp_d, exp_f);
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) n_timeouts++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; out_ready = 1'b1;
    drive(3'd0, 1'b0, 32'd5, 32'd6, 32'd11, 3'b000);
    // reset held two cycles with an op offered: nothing may be accepted
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    idle(4);

    // back-to-back ADD stream
    lat_mode = 1'b1;
    send(3'd0, 1'b0, 32'd1, 32'd2, 32'd3, 3'b000);
    for (int k = 2; k <= 10; k++)
      send(3'd0, 1'b0, 32'd1, 32'(k), 32'(1 + k), 3'b000);

    // ADD/SUB boundaries
    send(3'd0, 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE, 3'b000);
    send(3'd0, 1'b1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 3'b011);
    send(3'd0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 3'b110);

    // shifts, compares, logic
    send(3'd5, 1'b1, 32'h8000_0000, 32'h24, 32'hF800_0000, 3'b000);
    send(3'd5, 1'b0, 32'h8000_0000, 32'h24, 32'h0800_0000, 3'b000);
    send(3'd1, 1'b0, 32'h8000_0000, 32'h24, 32'h0000_0000, 3'b100);
    send(3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1,  32'd1,         3'b000);
    send(3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1,  32'd0,         3'b100);
    send(3'd4, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 3'b000);
    send(3'd6, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 3'b000);
    send(3'd7, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 3'b000);
    idle(4);

    // full pipe, downstream stalls three cycles
    lat_mode = 1'b0;
    out_ready = 1'b0;
    send(3'd0, 1'b0, 32'd100, 32'd1, 32'd101, 3'b000);
    send(3'd0, 1'b0, 32'd100, 32'd2, 32'd102, 3'b000);
    drive(3'd0, 1'b0, 32'd100, 32'd3, 32'd103, 3'b000);
    idle(3);
    out_ready = 1'b1;
    send(3'd0, 1'b0, 32'd100, 32'd3, 32'd103, 3'b000);
    idle(4);

    // full pipe, global enable low three cycles with out_ready high
    out_ready = 1'b0;
    send(3'd4, 1'b0, 32'd200, 32'd1, 32'd201, 3'b000);
    send(3'd4, 1'b0, 32'd200, 32'd2, 32'd202, 3'b000);
    out_ready = 1'b1; enable = 1'b0;
    drive(3'd4, 1'b0, 32'd200, 32'd3, 32'd203, 3'b000);
    idle(3);
    enable = 1'b1;
    send(3'd4, 1'b0, 32'd200, 32'd3, 32'd203, 3'b000);
    idle(4);

    // reset with two ops in flight, then a fresh op
    send(3'd0, 1'b0, 32'd1, 32'd1, 32'd2, 3'b000);
    send(3'd0, 1'b0, 32'd2, 32'd2, 32'd4, 3'b000);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    lat_mode = 1'b1;
    send(3'd0, 1'b0, 32'd7, 32'd8, 32'd15, 3'b000);
    idle(4);

    // randomized ops with random backpressure and enable
    lat_mode = 1'b0;
    begin
      int          sent;
      int          guard;
      bit          pend;
      logic [2:0]  f;
      logic        f7;
      logic [31:0] a, b;
      sent = 0; guard = 0; pend = 1'b0;
      while (sent < 300 && guard < 20000) begin
        guard++;
        out_ready = ($urandom_range(0, 3) != 0);
        enable    = ($urandom_range(0, 7) != 0);
        if (!pend) begin
          if ($urandom_range(0, 3) != 0) begin
            f = 3'($urandom_range(0, 7)); f7 = 1'($urandom_range(0, 1));
            a = rnd_operand(); b = rnd_operand();
            drive(f, f7, a, b, ref_alu(f, f7, a, b), ref_flags(f, f7, a, b));
            pend = 1'b1;
          end else begin
            in_valid = 1'b0;
          end
        end
        @(negedge clk);
        if (in_valid && in_ready) begin
          sent++;
          pend = 1'b0;
        end
        @(posedge clk); #1;
      end
      if (sent < 300) n_timeouts++;
    end
    in_valid = 1'b0; out_ready = 1'b1; enable = 1'b1;

    // drain remaining results (bounded)
    begin
      int t;
      t = 0;
      while (q.size() != 0 && t < 100) begin
        t++;
        @(posedge clk);
      end
      if (q.size() != 0) n_timeouts++;
    end
    idle(3);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
